// File: rtl/spi_slave_fsm_pkg.sv
// Shared definitions for the SPI slave: default widths and FSM state encodings.
package spi_slave_fsm_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = DATA_W_DEF - 1;

  typedef enum logic [2:0] {
    IDLE,
    GET_CMD,
    READ_MEM,
    LOAD,
    SEND,
    GET_DATA,
    WRITE_MEM,
    DONE
  } state_e;

  // Bit counter must hold 0..w without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/spi_slave_fsm_if.sv
// Conditioned SPI pins plus memory-side bus of the SPI slave.
// slave modport is the FSM view; master modport is the SPI master / memory side.
interface spi_slave_fsm_if
  import spi_slave_fsm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              sclk_rise;
  logic              sclk_fall;
  logic              cs_cond;
  logic              mosi_cond;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              wr_en;
  logic              rd_req;
  logic              miso;
  logic              miso_oe;

  modport slave (
    input  sclk_rise, sclk_fall, cs_cond, mosi_cond, rdata,
    output addr, wdata, wr_en, rd_req, miso, miso_oe
  );

  modport master (
    output sclk_rise, sclk_fall, cs_cond, mosi_cond, rdata,
    input  addr, wdata, wr_en, rd_req, miso, miso_oe
  );

endinterface

// File: rtl/spi_slave_fsm_shiftreg.sv
// Generic MSB-first shift register: parallel load has priority over shift.
// Latency 1 clk for load or shift; no backpressure.
module spi_shiftreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load_i,
  input  logic [W-1:0] load_dat_i,
  input  logic         shift_i,
  input  logic         ser_i,
  output logic [W-1:0] par_o,
  output logic         ser_o
);

  logic [W-1:0] sr_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= load_dat_i;
    end else if (shift_i) begin
      sr_q <= {sr_q[W-2:0], ser_i};
    end
  end

  assign par_o = sr_q;
  assign ser_o = sr_q[W-1];

endmodule

// File: rtl/spi_slave_fsm.sv
// SPI slave command FSM: {addr,rw} command byte then one write byte in, or one read byte out.
// Strobes are registered and last 1 clk; deselect aborts everything except an issued write.
module spi_slave_fsm
  import spi_slave_fsm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic             clk,
  input  logic             reset_n,
  spi_slave_fsm_if.slave   bus
);

  localparam int              CNT_W = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_en_q;
  logic              rd_req_q;
  logic              miso_oe_q;

  logic [DATA_W-1:0] in_par;
  logic [DATA_W-1:0] out_par;
  logic [DATA_W-1:0] in_byte_d;
  logic              in_ser;
  logic              out_ser;
  logic              sel;
  logic              in_clr;
  logic              in_shift;
  logic              out_ld;
  logic              out_shift;

  // Deselect gates every shift so a pulse coincident with cs high is dropped.
  assign sel       = !bus.cs_cond;
  assign in_clr    = sel && (state_q == IDLE);
  assign in_shift  = sel && bus.sclk_rise && ((state_q == GET_CMD) || (state_q == GET_DATA));
  assign out_ld    = sel && (state_q == LOAD);
  assign out_shift = sel && bus.sclk_fall && (state_q == SEND);
  assign in_byte_d = {in_par[DATA_W-2:0], bus.mosi_cond};

  spi_shiftreg #(.W(DATA_W)) u_in_sr (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (in_clr),
    .load_dat_i ('0),
    .shift_i    (in_shift),
    .ser_i      (bus.mosi_cond),
    .par_o      (in_par),
    .ser_o      (in_ser)
  );

  spi_shiftreg #(.W(DATA_W)) u_out_sr (
    .clk        (clk),
    .reset_n    (reset_n),
    .load_i     (out_ld),
    .load_dat_i (bus.rdata),
    .shift_i    (out_shift),
    .ser_i      (1'b0),
    .par_o      (out_par),
    .ser_o      (out_ser)
  );

  logic unused_sr;
  assign unused_sr = ^{in_ser, in_par[DATA_W-1], out_par};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      miso_oe_q <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      rd_req_q  <= 1'b0;
      miso_oe_q <= 1'b0;
      if (bus.cs_cond && (state_q != WRITE_MEM)) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q <= GET_CMD;
            cnt_q   <= '0;
          end
          GET_CMD: begin
            if (bus.sclk_rise) begin
              if (cnt_q == LAST) begin
                cnt_q  <= '0;
                addr_q <= in_byte_d[DATA_W-1 -: ADDR_W];
                if (in_byte_d[0]) begin
                  state_q  <= READ_MEM;
                  rd_req_q <= 1'b1;
                end else begin
                  state_q <= GET_DATA;
                end
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          READ_MEM: state_q <= LOAD;
          LOAD: begin
            state_q   <= SEND;
            cnt_q     <= '0;
            miso_oe_q <= 1'b1;
          end
          SEND: begin
            if (bus.sclk_fall && (cnt_q == LAST)) begin
              state_q <= DONE;
              cnt_q   <= '0;
            end else begin
              miso_oe_q <= 1'b1;
              if (bus.sclk_fall) begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          GET_DATA: begin
            if (bus.sclk_rise) begin
              if (cnt_q == LAST) begin
                cnt_q   <= '0;
                wdata_q <= in_byte_d;
                state_q <= WRITE_MEM;
                wr_en_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + CNT_W'(1);
              end
            end
          end
          // The strobe is already on the bus; deselect only picks the exit.
          WRITE_MEM: state_q <= bus.cs_cond ? IDLE : DONE;
          DONE:      state_q <= DONE;
          default:   state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.miso_oe = miso_oe_q;
  assign bus.miso    = miso_oe_q & out_ser;

endmodule
